mem_port_arbiter: RTL

Shares the single unified instruction/data memory between the multi-cycle CPU controller/datapath and the program loader, which fills memory before and between runs. Uses a per-requester req/ack handshake and a fixed-latency memory access sequence. CPU memory accesses (fetch via IorD=0, lw/sw via IorD=1) stall until ack, so the CPU controller holds its state while waiting.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the CPU and the program loader.
// Round-robin by default; define ARB_CPU_PRIORITY_EN to give the CPU fixed priority.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_ack,
   output logic [DW-1:0] ldr_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   // Handshake: a requester raises req with we/addr/wdata and holds them stable
   // until its one-cycle ack; inputs are only sampled while the arbiter is IDLE.

   state_t          state;
   state_t          state_nx;
   logic [3:0]      cnt;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic            any_req;
   logic            win;

   always_comb begin
      any_req = cpu_req | ldr_req;
      win     = 1'b0;
      if (cpu_req && ldr_req) begin
`ifdef ARB_CPU_PRIORITY_EN
         win = 1'b0;
`else
         win = ~owner;
`endif
      end else begin
         win = ldr_req;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ACCESS;
         ACCESS:  if (cnt == 4'd0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         owner     <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cpu_rdata <= '0;
         ldr_rdata <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner   <= win;
                  we_q    <= win ? ldr_we    : cpu_we;
                  addr_q  <= win ? ldr_addr  : cpu_addr;
                  wdata_q <= win ? ldr_wdata : cpu_wdata;
                  cnt     <= CNT_INIT;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (!we_q) begin
                  // mem_rdata is only valid in the last access cycle
                  if (owner) ldr_rdata <= mem_rdata;
                  else       cpu_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_read  = (state == ACCESS) && !we_q;
      mem_write = (state == ACCESS) && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      cpu_ack   = (state == DONE) && !owner;
      ldr_ack   = (state == DONE) && owner;
      busy      = (state != IDLE);
   end

endmodule
